// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator: access size, fault
// code, FSM state and the byte-lane mask used by the load/store aligner.
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {F_NONE, F_MISALIGN, F_ROM, F_RANGE} fault_e;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

  // Bytes of the 64-bit word touched by an access of this size at this offset.
  function automatic logic [63:0] lane_mask(size_e size, logic [2:0] offset);
    logic [63:0] base;
    case (size)
      SZ_B:    base = 64'h0000_0000_0000_00FF;
      SZ_H:    base = 64'h0000_0000_0000_FFFF;
      SZ_W:    base = 64'h0000_0000_FFFF_FFFF;
      default: base = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return base << {offset, 3'b000};
  endfunction

  function automatic logic is_misaligned(size_e size, logic [2:0] offset);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return offset[0];
      SZ_W:    return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_align.sv
// Combinational data path: extracts and extends load lanes from a memory word,
// and merges right-aligned store data into the addressed lanes of that word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic        is_unsigned,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  logic [63:0] shifted;
  logic [63:0] mask;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    mask    = lane_mask(size_e'(size), offset);
    merged  = (word & ~mask) | ((wdata << {offset, 3'b000}) & mask);
    case (size_e'(size))
      SZ_B:    load_data = is_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SZ_H:    load_data = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    load_data = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request at a time, aligned 64-bit reads, sub-word
// stores by read-modify-write, faults reported without touching memory.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned ROM_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wr_data,
  output logic        mem_wr_enable,
  output logic        mem_rd_enable,
  input  logic [63:0] mem_rd_data
);

  state_e      state_q, state_d;
  fault_e      fault_q, fault_d;
  size_e       size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] word_q, word_d;

  logic [31:0] req_word_idx;
  fault_e      req_fault;
  logic [31:0] aligned_addr;
  logic [63:0] load_data;
  logic [63:0] merged;

  lsu_align u_align (
    .word        (word_q),
    .wdata       (wdata_q),
    .size        (size_q),
    .offset      (addr_q[2:0]),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  assign req_word_idx = {3'b000, req_addr[31:3]};
  assign aligned_addr = {addr_q[31:3], 3'b000};

  // Fault priority: misalignment, then range, then store into ROM.
  always_comb begin
    if (is_misaligned(size_e'(req_size), req_addr[2:0])) begin
      req_fault = F_MISALIGN;
    end else if (req_word_idx >= MEM_WORDS) begin
      req_fault = F_RANGE;
    end else if (req_we && (req_word_idx < ROM_WORDS)) begin
      req_fault = F_ROM;
    end else begin
      req_fault = F_NONE;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    fault_d       = fault_q;
    size_d        = size_q;
    addr_d        = addr_q;
    we_d          = we_q;
    uns_d         = uns_q;
    wdata_d       = wdata_q;
    word_d        = word_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = 64'd0;
    resp_fault    = 2'd0;
    mem_addr      = 32'd0;
    mem_wr_data   = 64'd0;
    mem_wr_enable = 1'b0;
    mem_rd_enable = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = ~rst;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = size_e'(req_size);
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          fault_d = req_fault;
          if (req_fault != F_NONE) begin
            state_d = S_RESP;
          end else if (req_we && (size_e'(req_size) == SZ_D)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        mem_rd_enable = 1'b1;
        mem_addr      = aligned_addr;
        word_d        = mem_rd_data;
        state_d       = we_q ? S_WR : S_RESP;
      end
      S_WR: begin
        mem_wr_enable = 1'b1;
        mem_addr      = aligned_addr;
        mem_wr_data   = merged;
        state_d       = S_RESP;
      end
      default: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        if ((fault_q == F_NONE) && !we_q) begin
          resp_rdata = load_data;
        end
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      fault_q <= F_NONE;
      size_q  <= SZ_B;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= 64'd0;
      word_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed scenarios plus random
// traffic, compared against a byte-addressed reference memory model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_enable;
  logic        mem_rd_enable;
  logic [63:0] mem_rd_data;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  fault;
    logic [63:0] rdata;
    logic [3:0]  lat;
    logic [1:0]  rd_cnt;
    logic [1:0]  wr_cnt;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic        bad;
  } obs_t;

  lsu_mem_master dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_fault    (resp_fault),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_enable (mem_wr_enable),
    .mem_rd_enable (mem_rd_enable),
    .mem_rd_data   (mem_rd_data)
  );

  always #5 clk = ~clk;

  // Environment memory the DUT talks to.
  logic [63:0] mem [0:255];
  assign mem_rd_data = mem[mem_addr[10:3]];
  always @(posedge clk) begin
    if (mem_wr_enable) mem[mem_addr[10:3]] <= mem_wr_data;
  end

  // Reference model state: plain byte array.
  logic [7:0] ref_bytes [0:2047];

  initial begin
    for (int w = 0; w < 256; w++) begin
      mem[w] = (w < 4) ? (64'hC3A5_0F1E_8D7C_6B00 | 64'(w)) : 64'd0;
      for (int b = 0; b < 8; b++) ref_bytes[w*8 + b] = mem[w][8*b +: 8];
    end
  end

  function automatic obs_t ref_model(input bit we, input logic [1:0] size, input bit uns,
                                     input logic [31:0] addr, input logic [63:0] wdata);
    obs_t        e;
    int          nbytes;
    int          base;
    logic [63:0] val;
    e      = '0;
    nbytes = 1 << size;
    if ((addr % nbytes) != 0)       e.fault = 2'd1;
    else if ((addr >> 3) >= 256)    e.fault = 2'd3;
    else if (we && (addr >> 3) < 4) e.fault = 2'd2;
    if (e.fault != 2'd0) begin
      e.lat = 4'd1;
      return e;
    end
    base = int'(addr & 32'hFFFF_FFF8);
    if (!we) begin
      val = 64'd0;
      for (int i = 0; i < nbytes; i++) val[8*i +: 8] = ref_bytes[int'(addr) + i];
      if (!uns && val[8*nbytes-1]) val = val | (~64'd0 << (8*nbytes));
      e.rdata   = val;
      e.lat     = 4'd2;
      e.rd_cnt  = 2'd1;
      e.rd_addr = 32'(base);
    end else begin
      for (int i = 0; i < nbytes; i++) ref_bytes[int'(addr) + i] = wdata[8*i +: 8];
      e.lat     = (nbytes == 8) ? 4'd2 : 4'd3;
      e.rd_cnt  = (nbytes == 8) ? 2'd0 : 2'd1;
      e.rd_addr = (nbytes == 8) ? 32'd0 : 32'(base);
      e.wr_cnt  = 2'd1;
      e.wr_addr = 32'(base);
      for (int i = 0; i < 8; i++) e.wr_data[8*i +: 8] = ref_bytes[base + i];
    end
    return e;
  endfunction

  // Runs one transaction and records what the DUT did; no judging here.
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [63:0] wdata,
                        input bit hold, output obs_t o);
    int n;
    o            = '0;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    n = 0;
    while (!req_ready) begin
      @(posedge clk); #1;
      if (resp_valid) o.bad = 1'b1;
      if (++n > 10) begin
        o.bad = 1'b1;
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (req_ready) o.bad = 1'b1;
      if (mem_rd_enable) begin
        if (o.rd_cnt != 2'd3) o.rd_cnt++;
        o.rd_addr = mem_addr;
      end
      if (mem_wr_enable) begin
        if (o.wr_cnt != 2'd3) o.wr_cnt++;
        o.wr_addr = mem_addr;
        o.wr_data = mem_wr_data;
      end
      if (resp_valid) begin
        o.lat   = 4'(c);
        o.fault = resp_fault;
        o.rdata = resp_rdata;
        return;
      end
      @(posedge clk); #1;
    end
    o.bad = 1'b1;
  endtask

  task automatic test_reset();
    logic [230:0] outs;
    #2;
    outs = {req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_wr_data, mem_wr_enable, mem_rd_enable};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, mem_wr_enable, mem_rd_enable} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_release got=%b exp=1000", {req_ready, resp_valid, mem_wr_enable, mem_rd_enable});
    end
  endtask

  task automatic test_store_load();
    obs_t o, e;
    do_req(1'b1, 2'd3, 1'b0, 32'h20, 64'h1122334455667788, 1'b0, o);
    e = ref_model(1'b1, 2'd3, 1'b0, 32'h20, 64'h1122334455667788);
    checks++;
    if (o !== e) begin failures++; $display("FAIL sd_0x20 got=%h exp=%h", o, e); end
    do_req(1'b0, 2'd0, 1'b0, 32'h23, 64'd0, 1'b0, o);
    e = ref_model(1'b0, 2'd0, 1'b0, 32'h23, 64'd0);
    checks++;
    if (o !== e || o.rdata !== 64'h55) begin failures++; $display("FAIL lb_0x23 got=%h exp=%h", o, e); end
    do_req(1'b0, 2'd1, 1'b0, 32'h26, 64'd0, 1'b0, o);
    e = ref_model(1'b0, 2'd1, 1'b0, 32'h26, 64'd0);
    checks++;
    if (o !== e || o.rdata !== 64'h1122) begin failures++; $display("FAIL lh_0x26 got=%h exp=%h", o, e); end
  endtask

  task automatic test_subword_store();
    obs_t o, e;
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 64'hAB, 1'b0, o);
    e = ref_model(1'b1, 2'd0, 1'b0, 32'h21, 64'hAB);
    checks++;
    if (o !== e || o.wr_data !== 64'h112233445566AB88) begin
      failures++; $display("FAIL sb_0x21 got=%h exp=%h", o, e);
    end
    do_req(1'b0, 2'd0, 1'b0, 32'h21, 64'd0, 1'b0, o);
    e = ref_model(1'b0, 2'd0, 1'b0, 32'h21, 64'd0);
    checks++;
    if (o !== e || o.rdata !== 64'hFFFFFFFFFFFFFFAB) begin failures++; $display("FAIL lb_0x21 got=%h exp=%h", o, e); end
    do_req(1'b0, 2'd0, 1'b1, 32'h21, 64'd0, 1'b0, o);
    e = ref_model(1'b0, 2'd0, 1'b1, 32'h21, 64'd0);
    checks++;
    if (o !== e || o.rdata !== 64'hAB) begin failures++; $display("FAIL lbu_0x21 got=%h exp=%h", o, e); end
  endtask

  task automatic test_faults();
    logic        we_t   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  size_t [5] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [31:0] addr_t [5] = '{32'h22, 32'h08, 32'h08, 32'h800, 32'h7F8};
    logic [1:0]  flt_t  [5] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd0};
    obs_t o, e;
    for (int i = 0; i < 5; i++) begin
      do_req(we_t[i], size_t[i], 1'b0, addr_t[i], 64'hDEAD_BEEF_0BAD_F00D, 1'b0, o);
      e = ref_model(we_t[i], size_t[i], 1'b0, addr_t[i], 64'hDEAD_BEEF_0BAD_F00D);
      checks++;
      if (o !== e || o.fault !== flt_t[i]) begin
        failures++; $display("FAIL fault_case%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    obs_t o, e;
    int   wr_seen;
    logic [230:0] outs;
    req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 64'hBEEF; req_valid = 1'b1;
    wr_seen = 0;
    for (int n = 0; n < 10 && !req_ready; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_rd_enable !== 1'b1) begin failures++; $display("FAIL rst_mid_in_rd got=%b exp=1", mem_rd_enable); end
    rst = 1'b1;
    #1;
    outs = {req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_wr_data, mem_wr_enable, mem_rd_enable};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL rst_mid_outputs got=%h exp=0", outs); end
    repeat (2) begin
      @(posedge clk); #1;
      if (mem_wr_enable) wr_seen++;
    end
    @(negedge clk) rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (mem_wr_enable) wr_seen++;
    end
    checks++;
    if (wr_seen != 0) begin failures++; $display("FAIL rst_mid_no_write got=%0d exp=0", wr_seen); end
    do_req(1'b0, 2'd3, 1'b0, 32'h40, 64'd0, 1'b0, o);
    e = ref_model(1'b0, 2'd3, 1'b0, 32'h40, 64'd0);
    checks++;
    if (o !== e || o.rdata !== 64'd0) begin failures++; $display("FAIL ld_0x40_after_rst got=%h exp=%h", o, e); end
  endtask

  task automatic rand_req(output bit we, output logic [1:0] size, output bit uns,
                          output logic [31:0] addr, output logic [63:0] wdata);
    int r, idx, off;
    we    = 1'($urandom_range(0, 1));
    size  = 2'($urandom_range(0, 3));
    uns   = 1'($urandom_range(0, 1));
    wdata = {$urandom, $urandom};
    r = $urandom_range(0, 9);
    if (r == 0)      idx = $urandom_range(256, 300);
    else if (r == 1) idx = $urandom_range(250, 255);
    else             idx = $urandom_range(0, 15);
    off = $urandom_range(0, 7);
    if ($urandom_range(0, 3) != 0) off = off & ~((1 << size) - 1);
    addr = 32'(idx * 8 + off);
  endtask

  task automatic test_random();
    bit we, uns;
    logic [1:0] size;
    logic [31:0] addr;
    logic [63:0] wdata;
    obs_t o, e;
    for (int i = 0; i < 60; i++) begin
      rand_req(we, size, uns, addr, wdata);
      do_req(we, size, uns, addr, wdata, 1'b0, o);
      e = ref_model(we, size, uns, addr, wdata);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random%0d we=%0d sz=%0d a=%h got=%h exp=%h", i, we, size, addr, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit we, uns;
    logic [1:0] size;
    logic [31:0] addr;
    logic [63:0] wdata;
    obs_t o, e;
    for (int i = 0; i < 20; i++) begin
      rand_req(we, size, uns, addr, wdata);
      do_req(we, size, uns, addr, wdata, 1'b1, o);
      e = ref_model(we, size, uns, addr, wdata);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b%0d we=%0d sz=%0d a=%h got=%h exp=%h", i, we, size, addr, o, e);
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      failures++; $display("FAIL b2b_tail got=%b exp=01", {resp_valid, req_ready});
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_subword_store();
    test_faults();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the core's execute stage and the 64-bit-word data memory (256 words; words 0..3 are ROM).
- Accepts byte, half, word and double accesses at byte addresses.
- Loads: issues aligned 64-bit reads, then extracts and sign- or zero-extends the addressed lanes.
- Sub-word stores: read-modify-write. Misaligned, out-of-range and ROM-store faults are trapped before any memory write is issued.

Parameters:
- MEM_WORDS, 256, total 64-bit words in data memory.
- ROM_WORDS, 4, number of low words that are read-only.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req_valid  input  1  core request present
- req_ready  output  1  unit can accept a request this cycle
- req_we  input  1  1=store, 0=load
- req_size  input  2  0=B, 1=H, 2=W, 3=D
- req_unsigned  input  1  zero-extend the load result
- req_addr  input  32  byte address
- req_wdata  input  64  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  64  extended load data (0 for stores and faults)
- resp_fault  output  2  0=none, 1=misaligned, 2=ROM store, 3=out of range
- mem_addr  output  32  aligned byte address to memory
- mem_wr_data  output  64  merged write word
- mem_wr_enable  output  1  memory write strobe
- mem_rd_enable  output  1  memory read strobe
- mem_rd_data  input  64  memory read data, combinational from mem_addr

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - While rst is high, all outputs are 0 and the FSM is in IDLE.
  - Asserting rst in any state aborts the operation; no write strobe follows, even if the FSM was in RD of a store.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1; all mem_* outputs are 0.
  - On req_valid, latch addr, size, we, unsigned and wdata.
  - Fault check, in priority order:
    - misaligned (addr[size-1:0]!=0) -> 1;
    - word index addr[31:3] >= MEM_WORDS -> 3;
    - store with word index < ROM_WORDS -> 2.
  - Next state:
    - any fault -> RESP;
    - load or sub-word store -> RD;
    - size-D store -> WR.
- RD:
  - mem_rd_enable=1, mem_addr = latched addr with bits [2:0] cleared.
  - Capture mem_rd_data into the word register.
  - Next: load -> RESP; store -> WR.
- WR:
  - mem_wr_enable=1 for exactly one cycle, same aligned mem_addr.
  - mem_wr_data = captured word with the lanes selected by size and offset replaced by req_wdata; for size D it is req_wdata unchanged.
  - Next: RESP.
- RESP:
  - resp_valid=1 for one cycle; resp_rdata and resp_fault valid in this cycle.
  - req_ready=0. Next: IDLE.
- Byte order and extension:
  - Little-endian; byte offset is addr[2:0].
  - Load data = word >> (8*offset), truncated to size, then sign-extended (req_unsigned=0) or zero-extended to 64 bits.
- Latency, with the request accepted at edge T, resp_valid high during the cycle after edge:
  - load: T+2;
  - sub-word store: T+3;
  - size-D store: T+2;
  - fault: T+1.
- Throughput: one request outstanding. A new request is accepted no earlier than the cycle after RESP.
- Faulted accesses never assert mem_rd_enable or mem_wr_enable.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package lsu_pkg holds:
  - size_e {SZ_B, SZ_H, SZ_W, SZ_D};
  - fault_e {F_NONE, F_MISALIGN, F_ROM, F_RANGE};
  - state_e {S_IDLE, S_RD, S_WR, S_RESP};
  - byte-lane mask function.
- One sub-module, lsu_align: combinational extract/extend for loads and lane merge for stores, instantiated once.

Test Plan:
- Full store and byte loads:
  - sd 0x20 data 0x1122334455667788 -> one mem_wr_enable pulse, mem_addr=0x20, resp_valid at T+2, fault 0.
  - Then lb 0x23 -> resp_rdata 0x55.
  - Then lh 0x26 -> 0x1122.
- Sub-word store (read-modify-write):
  - sb 0x21 data 0xAB -> RD then WR, mem_wr_data 0x112233445566AB88.
  - Then lb 0x21 -> 0xFFFFFFFFFFFFFFAB.
  - Then lbu 0x21 -> 0x00000000000000AB.
- Misaligned load: lw 0x22 -> resp_fault 1 at T+1, resp_rdata 0, no mem strobes.
- ROM store:
  - sw 0x08 -> fault 2, mem_wr_enable never high.
  - ld 0x08 -> normal read, fault 0.
- Out of range: ld 0x800 (word 256) -> fault 3, no strobes. ld 0x7F8 -> fault 0.
- Reset mid-operation:
  - rst pulsed during RD of sh 0x40 data 0xBEEF -> no mem_wr_enable, and ld 0x40 afterwards returns 0.
  - Back-to-back requests with req_valid held high -> req_ready deasserts between requests and each completes with a single resp_valid.
